// File: rtl/rks_pkg.sv
`timescale 1ns/1ps
// Shared constants for the RKS tape loader: FSM state codes, format-error codes, accepted index.
// Latency: n/a (package only).
// Backpressure: n/a.
package rks_pkg;

    // ioctl download index that carries RKS images
    localparam logic [4:0] RKS_INDEX = 5'd1;

    // FSM state codes; HDR0..CS_LO are contiguous so "loading" is a range test
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_HDR0  = 4'd1;
    localparam logic [3:0] ST_HDR1  = 4'd2;
    localparam logic [3:0] ST_HDR2  = 4'd3;
    localparam logic [3:0] ST_HDR3  = 4'd4;
    localparam logic [3:0] ST_DATA  = 4'd5;
    localparam logic [3:0] ST_CS_HI = 4'd6;
    localparam logic [3:0] ST_CS_LO = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;
    localparam logic [3:0] ST_ERR   = 4'd9;

    // fmt_err codes
    localparam logic [1:0] FE_NONE  = 2'd0;
    localparam logic [1:0] FE_RANGE = 2'd1;
    localparam logic [1:0] FE_TRUNC = 2'd2;
    localparam logic [1:0] FE_OVR   = 2'd3;

endpackage

// File: rtl/rks_loader_if.sv
`timescale 1ns/1ps
// Bundle of the ioctl download stream, the sram write port and the status outputs of rks_loader.
// Latency: n/a (wiring only).
// Backpressure: ram_we is held until ram_ack; the ioctl side has no backpressure.
// master = host/top level side, slave = the loader.
interface rks_loader_if;
    logic        ioctl_download;
    logic [4:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_data;
    logic        ram_we;
    logic        ram_ack;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic [15:0] run_addr;
    logic        busy;
    logic        done;
    logic        cs_err;
    logic [1:0]  fmt_err;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, ram_ack,
        input  ram_we, ram_addr, ram_din, run_addr, busy, done, cs_err, fmt_err
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data, ram_ack,
        output ram_we, ram_addr, ram_din, run_addr, busy, done, cs_err, fmt_err
    );
endinterface

// File: rtl/rks_csum.sv
`timescale 1ns/1ps
// RKS payload checksum accumulator: 16-bit {hi,lo}, lo carry feeds hi except on the final byte.
// Latency: cs reflects a byte one cycle after en.
// Backpressure: none; accumulates whenever en is high.
// Ports: clk_sys/reset, clr (restart at 0), en (byte valid), last (final payload byte), byte_in, cs.
module rks_csum (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        last,
    input  logic [7:0]  byte_in,
    output logic [15:0] cs
);
    logic [8:0] lo_sum;

    assign lo_sum = {1'b0, cs[7:0]} + {1'b0, byte_in};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cs <= '0;
        end else if (clr) begin
            cs <= '0;
        end else if (en) begin
            cs[7:0] <= lo_sum[7:0];
            // the final byte only touches the low half
            if (!last) begin
                cs[15:8] <= cs[15:8] + byte_in + {7'd0, lo_sum[8]};
            end
        end
    end
endmodule

// File: rtl/rks_loader.sv
`timescale 1ns/1ps
// RKS tape image parser: header/payload/checksum from the ioctl stream into addressed sram writes.
// Latency: a byte is seen 3 clk_sys after ioctl_wr rises; ram_we follows on the next edge.
// Backpressure: ram_we held until ram_ack; a byte arriving while a write is still pending is an overrun error.
// Ports: clk_sys, reset, io (slave side of rks_loader_if: ioctl stream in, ram write port and status out).
module rks_loader
    import rks_pkg::*;
#(
    parameter logic [24:0] BASE     = 25'h0000000,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic         clk_sys,
    input  logic         reset,
    rks_loader_if.slave  io
);
    logic        wr_s1, wr_s2, wr_s3;
    logic [7:0]  dat_s1, dat_s2;
    logic        sess_q, dl_q;
    logic [3:0]  state;
    logic [15:0] start_a, end_a, ptr;
    logic [7:0]  cs_hi_rx;
    logic [15:0] cs;

    logic byte_stb, sess_now, sess_start, in_load, abort, we_busy, take_data, is_last;

    // data travels through the same two stages as the strobe so both line up
    assign byte_stb   = wr_s2 & ~wr_s3;
    assign sess_now   = io.ioctl_download && (io.ioctl_index == RKS_INDEX);
    assign sess_start = sess_now & ~sess_q;
    assign in_load    = (state >= ST_HDR0) && (state <= ST_CS_LO);
    assign abort      = dl_q && !io.ioctl_download && in_load;
    // an ack in this cycle retires the old write, so a byte arriving now is not an overrun
    assign we_busy    = io.ram_we && !io.ram_ack;
    assign is_last    = (ptr == end_a);
    assign take_data  = (state == ST_DATA) && byte_stb && !we_busy && !abort && !sess_start;

    rks_csum u_csum (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (sess_start),
        .en      (take_data),
        .last    (is_last),
        .byte_in (dat_s2),
        .cs      (cs)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_s1       <= 1'b0;
            wr_s2       <= 1'b0;
            wr_s3       <= 1'b0;
            dat_s1      <= '0;
            dat_s2      <= '0;
            sess_q      <= 1'b0;
            dl_q        <= 1'b0;
            state       <= ST_IDLE;
            start_a     <= '0;
            end_a       <= '0;
            ptr         <= '0;
            cs_hi_rx    <= '0;
            io.ram_we   <= 1'b0;
            io.ram_addr <= '0;
            io.ram_din  <= '0;
            io.run_addr <= '0;
            io.busy     <= 1'b0;
            io.done     <= 1'b0;
            io.cs_err   <= 1'b0;
            io.fmt_err  <= FE_NONE;
        end else begin
            wr_s1  <= io.ioctl_wr;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            dat_s1 <= io.ioctl_data;
            dat_s2 <= dat_s1;
            sess_q <= sess_now;
            dl_q   <= io.ioctl_download;

            // a pending write retires on ack in every state, including ERR
            if (io.ram_ack) begin
                io.ram_we <= 1'b0;
            end

            if (sess_start) begin
                state      <= ST_HDR0;
                io.busy    <= 1'b1;
                io.done    <= 1'b0;
                io.cs_err  <= 1'b0;
                io.fmt_err <= FE_NONE;
                io.ram_we  <= 1'b0;
            end else if (abort) begin
                state      <= ST_ERR;
                io.busy    <= 1'b0;
                io.fmt_err <= FE_TRUNC;
            end else if (byte_stb) begin
                case (state)
                    ST_HDR0: begin
                        start_a[7:0] <= dat_s2;
                        state        <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        start_a[15:8] <= dat_s2;
                        state         <= ST_HDR2;
                    end
                    ST_HDR2: begin
                        end_a[7:0] <= dat_s2;
                        state      <= ST_HDR3;
                    end
                    ST_HDR3: begin
                        end_a[15:8] <= dat_s2;
                        if ({dat_s2, end_a[7:0]} < start_a) begin
                            io.fmt_err <= FE_RANGE;
                            io.busy    <= 1'b0;
                            state      <= ST_ERR;
                        end else begin
                            ptr         <= start_a;
                            io.run_addr <= start_a;
                            state       <= ST_DATA;
                        end
                    end
                    ST_DATA, ST_CS_HI, ST_CS_LO: begin
                        if (we_busy) begin
                            // pending write still completes on its ack; this byte is dropped
                            io.fmt_err <= FE_OVR;
                            io.busy    <= 1'b0;
                            state      <= ST_ERR;
                        end else if (state == ST_DATA) begin
                            io.ram_din  <= dat_s2;
                            io.ram_addr <= BASE + {9'd0, ptr};
                            io.ram_we   <= 1'b1;
                            // compare before increment so end=FFFF never wraps
                            if (is_last) begin
                                state <= ST_CS_HI;
                            end else begin
                                ptr <= ptr + 16'd1;
                            end
                        end else if (state == ST_CS_HI) begin
                            cs_hi_rx <= dat_s2;
                            state    <= ST_CS_LO;
                        end else begin
                            if (CHECK_EN && ({cs_hi_rx, dat_s2} != cs)) begin
                                io.cs_err <= 1'b1;
                            end
                            io.done <= 1'b1;
                            io.busy <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end
                    default: ; // IDLE, DONE and ERR ignore bytes
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rks_loader.sv
`timescale 1ns/1ps
module tb_rks_loader;
    logic clk_sys = 1'b0;
    logic reset;

    always #5 clk_sys = ~clk_sys;

    rks_loader_if ai ();
    rks_loader_if bi ();

    rks_loader #(.BASE(25'h0000000), .CHECK_EN(1'b1)) dut_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (ai.slave)
    );

    rks_loader #(.BASE(25'h1000000), .CHECK_EN(1'b0)) dut_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (bi.slave)
    );

    // second instance sees the same stream, with an immediate ack
    assign bi.ioctl_download = ai.ioctl_download;
    assign bi.ioctl_index    = ai.ioctl_index;
    assign bi.ioctl_wr       = ai.ioctl_wr;
    assign bi.ioctl_data     = ai.ioctl_data;
    assign bi.ram_ack        = bi.ram_we;

    int n_tests = 0;
    int n_fail  = 0;

    int          ack_delay = 0;
    int          ack_cnt   = 0;
    int          wr_n      = 0;
    logic [24:0] wr_addr [0:15];
    logic [7:0]  wr_din  [0:15];
    logic [7:0]  img [$];

    // sram responder: acks a write ack_delay negedges after it is seen, logs it
    initial begin
        ai.ram_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            ai.ram_ack = 1'b0;
            if (ai.ram_we === 1'b1) begin
                if (ack_cnt >= ack_delay) begin
                    if (wr_n < 16) begin
                        wr_addr[wr_n] = ai.ram_addr;
                        wr_din[wr_n]  = ai.ram_din;
                    end
                    wr_n       = wr_n + 1;
                    ai.ram_ack = 1'b1;
                    ack_cnt    = 0;
                end else begin
                    ack_cnt = ack_cnt + 1;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ai.ioctl_data = b;
        ai.ioctl_wr   = 1'b1;
        tick(2);
        ai.ioctl_wr   = 1'b0;
        tick(2);
    endtask

    task automatic send_img();
        foreach (img[i]) send_byte(img[i]);
        tick(4);
    endtask

    task automatic start_session(input logic [4:0] idx);
        ai.ioctl_index    = idx;
        ai.ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_session();
        ai.ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ai.ioctl_download = 1'b0;
        ai.ioctl_index    = 5'd0;
        ai.ioctl_wr       = 1'b0;
        ai.ioctl_data     = 8'h00;
        tick(3);
        n_tests++;
        if ({ai.ram_we, ai.busy, ai.done, ai.cs_err, ai.fmt_err, ai.run_addr, ai.ram_addr, ai.ram_din} !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b busy=%b done=%b cs=%b fe=%0d run=%h addr=%h din=%h want all 0",
                     ai.ram_we, ai.busy, ai.done, ai.cs_err, ai.fmt_err, ai.run_addr, ai.ram_addr, ai.ram_din);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_good_image();
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40};
        send_img();
        n_tests++;
        if (ai.busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b want 1", ai.busy); end
        img = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h66};
        send_img();
        n_tests++;
        if (wr_n !== 3) begin n_fail++; $display("FAIL good_wr_count: got %0d want 3", wr_n); end
        n_tests++;
        if ({wr_addr[0], wr_addr[1], wr_addr[2]} !== {25'h4000, 25'h4001, 25'h4002}) begin
            n_fail++; $display("FAIL good_wr_addr: got %h %h %h want 4000 4001 4002", wr_addr[0], wr_addr[1], wr_addr[2]);
        end
        n_tests++;
        if ({wr_din[0], wr_din[1], wr_din[2]} !== 24'h112233) begin
            n_fail++; $display("FAIL good_wr_data: got %h %h %h want 11 22 33", wr_din[0], wr_din[1], wr_din[2]);
        end
        n_tests++;
        if ({ai.run_addr, ai.done, ai.busy, ai.cs_err, ai.fmt_err} !== {16'h4000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL good_status: got run=%h done=%b busy=%b cs=%b fe=%0d want 4000 1 0 0 0",
                               ai.run_addr, ai.done, ai.busy, ai.cs_err, ai.fmt_err);
        end
        n_tests++;
        if ({bi.ram_addr, bi.ram_din, bi.done} !== {25'h1004002, 8'h33, 1'b1}) begin
            n_fail++; $display("FAIL good_base_addr: got addr=%h din=%h done=%b want 1004002 33 1", bi.ram_addr, bi.ram_din, bi.done);
        end
        end_session();
    endtask

    task automatic test_bad_csum();
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22, 8'h33, 8'h33, 8'h99};
        send_img();
        n_tests++;
        if ({wr_n, wr_din[0], wr_din[1], wr_din[2]} !== {32'd3, 24'h112233}) begin
            n_fail++; $display("FAIL badcs_writes: got n=%0d %h %h %h want 3 11 22 33", wr_n, wr_din[0], wr_din[1], wr_din[2]);
        end
        n_tests++;
        if ({ai.done, ai.cs_err} !== 2'b11) begin
            n_fail++; $display("FAIL badcs_flag: got done=%b cs_err=%b want 1 1", ai.done, ai.cs_err);
        end
        n_tests++;
        if ({bi.done, bi.cs_err} !== 2'b10) begin
            n_fail++; $display("FAIL badcs_nocheck: got done=%b cs_err=%b want 1 0", bi.done, bi.cs_err);
        end
        end_session();
    endtask

    task automatic test_range();
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h80, 8'hFF, 8'h7F};
        send_img();
        n_tests++;
        if ({wr_n, ai.ram_we, ai.fmt_err, ai.busy, ai.done} !== {32'd0, 1'b0, 2'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL range_err: got n=%0d we=%b fe=%0d busy=%b done=%b want 0 0 1 0 0",
                               wr_n, ai.ram_we, ai.fmt_err, ai.busy, ai.done);
        end
        end_session();
    endtask

    task automatic test_trunc();
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22};
        send_img();
        end_session();
        tick(2);
        n_tests++;
        if ({wr_n, ai.fmt_err, ai.done, ai.busy} !== {32'd2, 2'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL trunc_err: got n=%0d fe=%0d done=%b busy=%b want 2 2 0 0", wr_n, ai.fmt_err, ai.done, ai.busy);
        end
    endtask

    task automatic test_overrun();
        ack_delay = 10; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22, 8'h33};
        send_img();
        tick(16);
        n_tests++;
        if ({wr_n, wr_din[0], wr_addr[0]} !== {32'd1, 8'h11, 25'h4000}) begin
            n_fail++; $display("FAIL ovr_writes: got n=%0d din=%h addr=%h want 1 11 4000", wr_n, wr_din[0], wr_addr[0]);
        end
        n_tests++;
        if ({ai.fmt_err, ai.ram_we, ai.busy, ai.done} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL ovr_err: got fe=%0d we=%b busy=%b done=%b want 3 0 0 0", ai.fmt_err, ai.ram_we, ai.busy, ai.done);
        end
        end_session();
    endtask

    task automatic test_stall_ack();
        ack_delay = 1; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22, 8'h33, 8'h33, 8'h66};
        send_img();
        n_tests++;
        if ({wr_n, ai.fmt_err, ai.done, ai.cs_err} !== {32'd3, 2'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL stall_ok: got n=%0d fe=%0d done=%b cs=%b want 3 0 1 0", wr_n, ai.fmt_err, ai.done, ai.cs_err);
        end
        end_session();
    endtask

    // ack lands in the same cycle as the next byte strobe
    task automatic test_back_to_back();
        ack_delay = 3; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22, 8'h33, 8'h33, 8'h66};
        send_img();
        n_tests++;
        if ({wr_n, ai.fmt_err, ai.done, ai.cs_err} !== {32'd3, 2'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL b2b_same_cycle: got n=%0d fe=%0d done=%b cs=%b want 3 0 1 0", wr_n, ai.fmt_err, ai.done, ai.cs_err);
        end
        n_tests++;
        if ({wr_din[0], wr_din[1], wr_din[2]} !== 24'h112233) begin
            n_fail++; $display("FAIL b2b_data: got %h %h %h want 11 22 33", wr_din[0], wr_din[1], wr_din[2]);
        end
        end_session();
    endtask

    // start == end == FFFF: one byte, no wrap; checksum = 005A
    task automatic test_single_ffff();
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h5A};
        send_img();
        n_tests++;
        if ({wr_n, wr_addr[0], wr_din[0]} !== {32'd1, 25'h0FFFF, 8'h5A}) begin
            n_fail++; $display("FAIL single_write: got n=%0d addr=%h din=%h want 1 0ffff 5a", wr_n, wr_addr[0], wr_din[0]);
        end
        n_tests++;
        if ({ai.run_addr, ai.done, ai.cs_err, ai.fmt_err} !== {16'hFFFF, 1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL single_status: got run=%h done=%b cs=%b fe=%0d want ffff 1 0 0", ai.run_addr, ai.done, ai.cs_err, ai.fmt_err);
        end
        end_session();
    endtask

    task automatic test_reset_mid();
        ack_delay = 10; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11};
        foreach (img[i]) send_byte(img[i]);
        n_tests++;
        if (ai.ram_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got we=%b want 1", ai.ram_we); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({ai.ram_we, ai.busy, ai.done, ai.cs_err, ai.fmt_err, ai.run_addr, ai.ram_addr, ai.ram_din} !== 55'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got we=%b busy=%b run=%h addr=%h din=%h want all 0",
                               ai.ram_we, ai.busy, ai.run_addr, ai.ram_addr, ai.ram_din);
        end
        ai.ioctl_download = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        ack_delay = 0; wr_n = 0;
        start_session(5'd1);
        img = '{8'h00, 8'h40, 8'h02, 8'h40, 8'h11, 8'h22, 8'h33, 8'h33, 8'h66};
        send_img();
        n_tests++;
        if ({wr_n, ai.run_addr, ai.done, ai.cs_err, ai.fmt_err} !== {32'd3, 16'h4000, 1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL rstmid_reload: got n=%0d run=%h done=%b cs=%b fe=%0d want 3 4000 1 0 0",
                               wr_n, ai.run_addr, ai.done, ai.cs_err, ai.fmt_err);
        end
        end_session();
        wr_n = 0;
        start_session(5'd2);
        img = '{8'h00, 8'h50, 8'h02, 8'h50};
        send_img();
        n_tests++;
        if ({ai.busy, ai.done, ai.run_addr} !== {1'b0, 1'b1, 16'h4000}) begin
            n_fail++; $display("FAIL idx2_ignored: got busy=%b done=%b run=%h want 0 1 4000", ai.busy, ai.done, ai.run_addr);
        end
        img = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
        send_img();
        n_tests++;
        if (wr_n !== 0) begin n_fail++; $display("FAIL idx2_nowrites: got %0d want 0", wr_n); end
        end_session();
    endtask

    initial begin
        test_reset();
        test_good_image();
        test_bad_csum();
        test_range();
        test_trunc();
        test_overrun();
        test_stall_ack();
        test_back_to_back();
        test_single_ffff();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rks_loader.md
Name: rks_loader

Overview:
- Parses an RKS tape image arriving on the ARM ioctl download stream (index 1) and turns it into addressed byte writes for the `sram` port.
- RKS layout: start address, end address, payload, checksum.
- Sits directly upstream of the `sram` write mux. It replaces the raw `ioctl_addr` path for RKS files, so images load to their own start address.
- Reports the entry address, completion and errors to the top level, which releases `io_reset`.

Parameters:
- BASE, 25'h0000000, 25-bit offset added to every RAM write address (selects the memory page).
- CHECK_EN, 1, when 0 the checksum is not compared and `cs_err` stays 0.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download active (level)
- ioctl_index  in  5  download index; only index 1 is accepted
- ioctl_wr  in  1  byte strobe from the clk_io domain; the block detects its rising edge
- ioctl_data  in  8  byte value, stable while `ioctl_wr` is high
- ram_we  out  1  write request, held high until acknowledged
- ram_ack  in  1  one-cycle pulse; the write was accepted
- ram_addr  out  25  BASE + current load address
- ram_din  out  8  byte to write
- run_addr  out  16  start address taken from the header
- busy  out  1  parse in progress
- done  out  1  image fully loaded (sticky)
- cs_err  out  1  checksum mismatch (sticky)
- fmt_err  out  2  format error: 0 none, 1 end<start, 2 truncated, 3 overrun

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - `ram_we`, `busy`, `done`, `cs_err` = 0; `fmt_err` = 0.
  - `run_addr`, `ram_addr` and `ram_din` = 0.
- Strobe handling:
  - A 2-flop synchroniser is applied to `ioctl_wr`; its rising edge is `byte_stb`.
  - `ioctl_data` is captured on the same edge.
  - At most one `byte_stb` per 2 clk_sys cycles.
- Session start:
  - Trigger: rising edge of (`ioctl_download` && `ioctl_index`==1), from any state.
  - Clears `done`, `cs_err`, `fmt_err` and the checksum; sets `busy`; enters HDR0.
  - A session restarted mid-load abandons the old one. A pending `ram_we` is dropped that cycle.
- States:
  - IDLE: ignores strobes.
  - HDR0 → HDR1 → HDR2 → HDR3: one byte each.
    - HDR0/HDR1 give `start` lo/hi; HDR2/HDR3 give `end` lo/hi.
    - On leaving HDR3: if `end` < `start`, `fmt_err`=1 and go to ERR. Otherwise `ptr`=`start`, `run_addr`=`start`, go to DATA.
  - DATA: each byte is latched to `ram_din`, `ram_addr`=BASE+`ptr`, and `ram_we`=1.
    - When `ram_ack` arrives, drop `ram_we`.
    - If `ptr`==`end`, go to CS_HI; else `ptr`++.
    - Length is `end`-`start`+1; `start`==`end` gives exactly 1 byte.
    - `end`=FFFF does not wrap: the transition happens on compare, before any increment.
  - CS_HI then CS_LO: stored checksum, high byte first. On leaving CS_LO, compare (if CHECK_EN), set `cs_err` on mismatch, then go to DONE.
  - DONE: `done`=1, `busy`=0; extra bytes are ignored.
  - ERR: `busy`=0, `done`=0; strobes are ignored until the next session start.
- Checksum (16-bit `cs` = {hi,lo}), per payload byte b:
  - Non-final byte: `lo`' = `lo`+b (8-bit, carry c); `hi`' = `hi`+b+c.
  - Final byte (`ptr`==`end`): `lo`' = `lo`+b only.
- Overrun: a `byte_stb` while `ram_we` is still high sets `fmt_err`=3 and goes to ERR. The pending write still completes on `ram_ack`; the new byte is discarded.
- Truncation: `ioctl_download` falling while in HDR*/DATA/CS_* sets `fmt_err`=2, goes to ERR, and drops `ram_we` once the pending write is acknowledged.
- Simultaneous `byte_stb` and `ram_ack` in the same cycle: the ack retires the old write first, then the new byte is accepted (no overrun).

Decomposition:
- Shared package `rks_pkg`:
  - FSM state enum (IDLE, HDR0–HDR3, DATA, CS_HI, CS_LO, DONE, ERR).
  - `fmt_err` codes FE_NONE/FE_RANGE/FE_TRUNC/FE_OVR.
  - Constant RKS_INDEX=5'd1.
- One sub-module, `rks_csum`: inputs clk_sys, reset, clr, en, last, byte; output 16-bit `cs`. It implements the carry rule above.

Test Plan:
- Image 00 40 02 40 11 22 33 + correct checksum, instant ack → writes at 0x4000/1/2 of 11/22/33; `run_addr`=4000; `done`=1; `cs_err`=0.
- Same image with the checksum lo byte flipped → identical writes, `done`=1, `cs_err`=1; with CHECK_EN=0, `cs_err`=0.
- Header `start`=8000, `end`=7FFF → no `ram_we`; `fmt_err`=1; `busy`=0.
- `ioctl_download` drops after 2 of 3 payload bytes → 2 writes; `fmt_err`=2; `done`=0.
- `ram_ack` delayed 10 cycles with strobes every 4 cycles → first write completes, `fmt_err`=3; a stalled ack of 1 cycle with strobes every 4 cycles gives no error.
- Async `reset` pulse during DATA with `ram_we` high → all outputs 0 within the same cycle; next download index 1 loads normally; an index 2 download is ignored.
